// File: rtl/snn_fixed_pkg.sv
// Shared sign-magnitude Q16.16 number format, helpers and the LIF stage state encoding.
package snn_fixed_pkg;

  localparam int N  = 32;
  localparam int Q  = 16;
  localparam int RW = 8;

  typedef logic [N-1:0] fixed_t;

  localparam fixed_t FX_ZERO    = 32'h0000_0000;
  localparam fixed_t FX_ONE     = 32'h0001_0000;
  localparam fixed_t FX_MAX_POS = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    DIFF,
    MUL_LEAK,
    MUL_GAIN,
    SUM,
    FIRE,
    OUT,
    BYPASS
  } lif_state_t;

  // Folds negative zero onto +0 so downstream logic only ever sees one zero.
  function automatic fixed_t fx_norm(input fixed_t a);
    return (a[N-2:0] == '0) ? FX_ZERO : a;
  endfunction

  function automatic fixed_t fx_neg(input fixed_t a);
    return (a[N-2:0] == '0) ? FX_ZERO : {~a[N-1], a[N-2:0]};
  endfunction

  // Signed a >= b on sign-magnitude values; either zero encoding counts as +0.
  function automatic logic fx_ge(input fixed_t a, input fixed_t b);
    logic a_neg;
    logic b_neg;
    a_neg = a[N-1] & (|a[N-2:0]);
    b_neg = b[N-1] & (|b[N-2:0]);
    if (a_neg != b_neg) return b_neg;
    else if (!a_neg)    return a[N-2:0] >= b[N-2:0];
    else                return a[N-2:0] <= b[N-2:0];
  endfunction

endpackage

// File: rtl/fx_sat_add.sv
// Combinational sign-magnitude adder that saturates the magnitude instead of wrapping.
module fx_sat_add
  import snn_fixed_pkg::*;
#(
  parameter int N = snn_fixed_pkg::N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  logic         sa, sb;
  logic [N-2:0] ma, mb;
  logic [N-1:0] mag_sum;
  logic [N-2:0] res_mag;
  logic         res_sign;

  assign sa      = a[N-1];
  assign sb      = b[N-1];
  assign ma      = a[N-2:0];
  assign mb      = b[N-2:0];
  assign mag_sum = {1'b0, ma} + {1'b0, mb};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    res_mag  = '0;
    res_sign = 1'b0;
    if (sa == sb) begin
      res_mag  = mag_sum[N-1] ? '1 : mag_sum[N-2:0];
      res_sign = sa;
    end else if (ma >= mb) begin
      res_mag  = ma - mb;
      res_sign = sa;
    end else begin
      res_mag  = mb - ma;
      res_sign = sb;
    end
  end

  assign y = {res_sign & (|res_mag), res_mag};

endmodule

// File: rtl/lif_neuron_stage.sv
// Leaky integrate-and-fire update stage: one shared multiplier and two chained
// saturating adders sequenced by a small FSM, valid/ready on both sides.
module lif_neuron_stage
  import snn_fixed_pkg::*;
#(
  parameter int N  = snn_fixed_pkg::N,
  parameter int Q  = snn_fixed_pkg::Q,
  parameter int RW = snn_fixed_pkg::RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  i_in,
  input  logic [N-1:0]  cfg_v_rest,
  input  logic [N-1:0]  cfg_v_reset,
  input  logic [N-1:0]  cfg_v_th,
  input  logic [N-1:0]  cfg_leak,
  input  logic [N-1:0]  cfg_gain,
  input  logic [RW-1:0] cfg_refrac,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  v_out,
  output logic          spike
);

  lif_state_t state, state_d;

  logic [N-1:0]  v, d, p1, p2, v_new, i_r;
  logic [N-1:0]  v_rest_r, v_reset_r, v_th_r, leak_r, gain_r;
  logic [RW-1:0] refrac_r, refrac_cnt;
  logic          spike_r;

  logic [N-1:0]  mul_a, mul_b, mul_y;
  logic [N-2:0]  mul_mag;
  logic [N-1:0]  add1_a, add1_b, add1_y, add2_y;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign v_out     = v;
  assign spike     = spike_r & out_valid;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (in_valid) state_d = (refrac_cnt == '0) ? DIFF : BYPASS;
      DIFF:     state_d = MUL_LEAK;
      MUL_LEAK: state_d = MUL_GAIN;
      MUL_GAIN: state_d = SUM;
      SUM:      state_d = FIRE;
      FIRE:     state_d = OUT;
      BYPASS:   state_d = OUT;
      OUT:      if (out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Shared multiplier: leak*d in MUL_LEAK, gain*i otherwise; magnitude keeps bits [N-2+Q:Q].
  assign mul_a   = (state == MUL_LEAK) ? leak_r : gain_r;
  assign mul_b   = (state == MUL_LEAK) ? d      : i_r;
  assign mul_mag = (N-1)'(({{(N-1){1'b0}}, mul_a[N-2:0]} *
                           {{(N-1){1'b0}}, mul_b[N-2:0]}) >> Q);
  assign mul_y   = {(mul_a[N-1] ^ mul_b[N-1]) & (|mul_mag), mul_mag};

  // DIFF borrows the first adder for v_rest - v; SUM chains both adders.
  assign add1_a = (state == DIFF) ? v_rest_r  : v;
  assign add1_b = (state == DIFF) ? fx_neg(v) : p1;

  fx_sat_add #(.N(N)) u_add1 (.a(add1_a), .b(add1_b), .y(add1_y));
  fx_sat_add #(.N(N)) u_add2 (.a(add1_y), .b(p2),     .y(add2_y));

  // NOTE: the datapath is a handful of flops, not a memory, so all of it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v          <= '0;
      d          <= '0;
      p1         <= '0;
      p2         <= '0;
      v_new      <= '0;
      i_r        <= '0;
      v_rest_r   <= '0;
      v_reset_r  <= '0;
      v_th_r     <= '0;
      leak_r     <= '0;
      gain_r     <= '0;
      refrac_r   <= '0;
      refrac_cnt <= '0;
      spike_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          i_r       <= fx_norm(i_in);
          v_rest_r  <= fx_norm(cfg_v_rest);
          v_reset_r <= fx_norm(cfg_v_reset);
          v_th_r    <= fx_norm(cfg_v_th);
          leak_r    <= fx_norm(cfg_leak);
          gain_r    <= fx_norm(cfg_gain);
          refrac_r  <= cfg_refrac;
        end
        DIFF:     d     <= add1_y;
        MUL_LEAK: p1    <= mul_y;
        MUL_GAIN: p2    <= mul_y;
        SUM:      v_new <= add2_y;
        FIRE: begin
          if (fx_ge(v_new, v_th_r)) begin
            v          <= v_reset_r;
            spike_r    <= 1'b1;
            refrac_cnt <= refrac_r;
          end else begin
            v       <= v_new;
            spike_r <= 1'b0;
          end
        end
        // Only reachable with a nonzero count, so the decrement cannot underflow.
        BYPASS: begin
          v          <= v_reset_r;
          spike_r    <= 1'b0;
          refrac_cnt <= refrac_cnt - RW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_stage.sv
// Scoreboard bench for lif_neuron_stage: expectations queued at drive time, popped at out_valid.
module tb_lif_neuron_stage;
  import snn_fixed_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] i_in = '0;
  logic [31:0] cfg_v_rest = '0, cfg_v_reset = '0, cfg_v_th = '0, cfg_leak = '0, cfg_gain = '0;
  logic [7:0]  cfg_refrac = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] v_out;
  logic        spike;

  typedef struct {
    logic [31:0] v;
    logic        spike;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lif_neuron_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .i_in(i_in),
    .cfg_v_rest(cfg_v_rest), .cfg_v_reset(cfg_v_reset), .cfg_v_th(cfg_v_th),
    .cfg_leak(cfg_leak), .cfg_gain(cfg_gain), .cfg_refrac(cfg_refrac),
    .out_valid(out_valid), .out_ready(out_ready), .v_out(v_out), .spike(spike)
  );

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_cfg(input logic [31:0] rest, input logic [31:0] vres, input logic [31:0] th,
                         input logic [31:0] leak, input logic [31:0] gain, input logic [7:0] refrac);
    cfg_v_rest  = rest;
    cfg_v_reset = vres;
    cfg_v_th    = th;
    cfg_leak    = leak;
    cfg_gain    = gain;
    cfg_refrac  = refrac;
  endtask

  // Waits for IDLE, presents one sample, returns just after the accept edge.
  task automatic drive(input logic [31:0] i, input string name);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL %s in_ready: got %b expected 1", name, in_ready);
    end
    in_valid = 1'b1;
    i_in     = i;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    i_in     = 32'h7FFF_0000;
  endtask

  // Counts edges from the accept edge (counted as 1) until out_valid, then scores the result.
  task automatic collect(input string name, input bit post_check);
    exp_t e;
    int   lat = 1;
    while (1) begin
      @(negedge clk);
      if (out_valid || lat >= 40) break;
      @(posedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL %s timeout: out_valid still 0 after %0d cycles", name, lat);
      return;
    end
    checks++;
    if (v_out !== e.v) begin
      failures++;
      $display("FAIL %s v_out: got %h expected %h", name, v_out, e.v);
    end
    checks++;
    if (spike !== e.spike) begin
      failures++;
      $display("FAIL %s spike: got %b expected %b", name, spike, e.spike);
    end
    checks++;
    if (lat != e.lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
    end
    if (post_check) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s release: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
      end
    end
  endtask

  task automatic sample(input logic [31:0] i, input logic [31:0] ev, input logic es,
                        input int elat, input string name);
    sb_q.push_back('{v: ev, spike: es, lat: elat});
    drive(i, name);
    collect(name, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || v_out !== 32'h0 || spike !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b v_out=%h spike=%b expected 1/0/0/0",
               in_ready, out_valid, v_out, spike);
    end
  endtask

  task automatic test_sub_threshold();
    set_cfg(32'h0, 32'h0, 32'h0005_0000, 32'h0000_8000, 32'h0001_0000, 8'd2);
    sample(32'h0002_0000, 32'h0002_0000, 1'b0, 6, "sub_1");
    sample(32'h0002_0000, 32'h0003_0000, 1'b0, 6, "sub_2");
    sample(32'h0002_0000, 32'h0003_8000, 1'b0, 6, "sub_3");
  endtask

  task automatic test_spike_refractory();
    do_reset();
    set_cfg(32'h0, 32'h0, 32'h0005_0000, 32'h0000_8000, 32'h0001_0000, 8'd2);
    sample(32'h0004_0000, 32'h0004_0000, 1'b0, 6, "spk_charge");
    sample(32'h0004_0000, 32'h0000_0000, 1'b1, 6, "spk_fire");
    sample(32'h0004_0000, 32'h0000_0000, 1'b0, 2, "spk_refrac_1");
    sample(32'h0004_0000, 32'h0000_0000, 1'b0, 2, "spk_refrac_2");
    sample(32'h0004_0000, 32'h0004_0000, 1'b0, 6, "spk_resume");
  endtask

  task automatic test_saturation();
    do_reset();
    set_cfg(32'h0, 32'h0, 32'h7FFF_FFFF, 32'h0, 32'h0001_0000, 8'd2);
    sample(32'h4000_0000, 32'h4000_0000, 1'b0, 6, "sat_1");
    sample(32'h4000_0000, 32'h0000_0000, 1'b1, 6, "sat_fire");
  endtask

  task automatic test_backpressure();
    do_reset();
    set_cfg(32'h0, 32'h0, 32'h0005_0000, 32'h0000_8000, 32'h0001_0000, 8'd2);
    out_ready = 1'b0;
    sb_q.push_back('{v: 32'h0, spike: 1'b0, lat: 6});
    drive(32'h8000_0000, "bp_negzero");
    collect("bp_negzero", 1'b0);
    // A competing sample stays presented while the result is stalled; it must be ignored.
    in_valid = 1'b1;
    i_in     = 32'h0005_0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || v_out !== 32'h0 || spike !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%b v_out=%h spike=%b in_ready=%b expected 1/0/0/0",
                 k, out_valid, v_out, spike, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    sample(32'h0001_0000, 32'h0001_0000, 1'b0, 6, "bp_after");
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_cfg(32'h0, 32'h0, 32'h0005_0000, 32'h0000_8000, 32'h0001_0000, 8'd2);
    sample(32'h0001_0000, 32'h0001_0000, 1'b0, 6, "mid_prime");
    drive(32'h0002_0000, "mid_abort");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || v_out !== 32'h0 || spike !== 1'b0) begin
      failures++;
      $display("FAIL mid_async: out_valid=%b v_out=%h spike=%b expected 0/0/0", out_valid, v_out, spike);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL mid_idle: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
    end
    sample(32'h0001_0000, 32'h0001_0000, 1'b0, 6, "mid_after");
  endtask

  initial begin
    test_reset();
    test_sub_threshold();
    test_spike_refractory();
    test_saturation();
    test_backpressure();
    test_reset_mid_op();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lif_neuron_stage.md
Name: lif_neuron_stage

Overview:
Sequential leaky integrate-and-fire neuron update stage. Consumes one input current sample per timestep and produces the updated membrane voltage plus a spike flag. It sits directly downstream of the fixed-point arithmetic library and reuses its number format, sign-magnitude Q16.16. One shared multiplier is time-multiplexed over a small FSM, with valid/ready handshakes on both sides.

Parameters:
N, 32, total word width (bit N-1 = sign, bits N-2:0 = magnitude)
Q, 16, fractional bits
RW, 8, refractory counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  stage can accept (high only in IDLE)
i_in  in  N  input current, sign-magnitude Q16.16
cfg_v_rest  in  N  resting voltage
cfg_v_reset  in  N  post-spike voltage
cfg_v_th  in  N  spike threshold
cfg_leak  in  N  leak factor (0..1)
cfg_gain  in  N  input gain
cfg_refrac  in  RW  refractory timesteps after a spike
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  downstream accepts result
v_out  out  N  updated membrane voltage
spike  out  1  spike this timestep (qualified by out_valid)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, v=+0, refrac_cnt=0.
  - Outputs: out_valid=0, spike=0, v_out=0, in_ready=1. in_ready is decoded from state.
- Accept: on a clock edge with in_valid & in_ready, capture i_in and all cfg_* into internal registers. cfg changes while busy are ignored.
- Number rules:
  - Negative zero (0x80000000) on any input is treated as +0. The block never outputs negative zero.
  - mult: sign = XOR of the signs; magnitude = product[N-2+Q:Q], truncated.
  - add: sign-magnitude, saturating at magnitude 0x7FFFFFFF with the sign kept. It does not wrap.
  - Compare: signed compare on sign-magnitude values.
- FSM states: IDLE, DIFF, MUL_LEAK, MUL_GAIN, SUM, FIRE, OUT, BYPASS.
  - IDLE: accept -> DIFF if refrac_cnt==0, else -> BYPASS.
  - DIFF: d = v_rest + (-v).
  - MUL_LEAK: p1 = leak * d (shared multiplier).
  - MUL_GAIN: p2 = gain * i (shared multiplier).
  - SUM: v_new = sat_add(sat_add(v, p1), p2).
  - FIRE:
    - If v_new >= v_th: v = v_reset, spike_r = 1, refrac_cnt = cfg_refrac.
    - Else: v = v_new, spike_r = 0.
    - Then -> OUT.
  - BYPASS: v = v_reset, spike_r = 0, refrac_cnt -= 1 -> OUT.
  - OUT: out_valid=1, v_out=v, spike=spike_r. Leaves on out_ready -> IDLE with out_valid=0 the next cycle.
- Latency, accept edge to out_valid high: 6 cycles when integrating, 2 cycles when in refractory. Throughput is one sample per (latency+1) cycles with out_ready tied high.
- v_out and spike hold stable while out_valid=1 and out_ready=0 (backpressure, no data loss).
- in_valid during a non-IDLE state is ignored (in_ready=0); the upstream block holds the sample.
- cfg_refrac=0: spike resets v, but the next sample integrates normally.
- refrac_cnt never underflows. BYPASS is entered only when the count is nonzero.
- Reset mid-operation: returns to IDLE immediately. The partial result is discarded and no out_valid is produced.

Decomposition:
- Package snn_fixed_pkg holds:
  - N, Q constants
  - typedef fixed_t (logic [N-1:0])
  - FX_ZERO, FX_ONE (0x00010000), FX_MAX_POS (0x7FFFFFFF)
  - state enum lif_state_t
  - functions fx_neg and fx_ge
- One sub-module, fx_sat_add: combinational sign-magnitude saturating adder. It is instantiated twice, chained in SUM; DIFF reuses the first instance via muxing.
- The multiplier is a single shared combinational instance with muxed operands.

Test Plan:
- Config for the first two scenarios: v_rest=0, leak=0x00008000, gain=0x00010000, v_th=0x00050000, v_reset=0, refrac=2.
- Sub-threshold: three samples i=0x00020000 -> v_out 0x00020000, 0x00030000, 0x00038000; spike=0; out_valid 6 cycles after each accept.
- Spike+refractory: i=0x00040000 twice -> v_out 0x00040000, then spike=1 with v_out=0. Next two samples: 2-cycle latency, v_out=0, spike=0. Third sample integrates again -> v_out 0x00040000.
- Saturation: leak=0, v_th=0x7FFFFFFF, i=0x40000000 twice -> 0x40000000, then saturated sum equals v_th -> spike=1, v_out=v_reset.
- Backpressure/neg-zero: i=0x80000000 with out_ready low for 10 cycles -> out_valid held, v_out=0x00000000 stable, in_ready=0 throughout; completes one cycle after out_ready rises.
- Reset mid-op: pull rst_n low in MUL_GAIN -> out_valid=0, v_out=0, spike=0 asynchronously; after release in_ready=1 and the next sample i=0x00010000 yields v_out 0x00010000.
